// File: rtl/sparse_pkg.sv
// Shared types and default sizing for the sparse entry buffer.
package sparse_pkg;

   // Assembler states: collecting bytes, then one cycle to hand the entry to the FIFO.
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StAssemble = 2'd1,
      StCommit   = 2'd2
   } asm_state_e;

   localparam int unsigned DefaultEntryBytes = 17;
   localparam int unsigned DefaultDepth      = 16;

endpackage

// File: rtl/edge_detect.sv
// Single-register edge detector producing a one-cycle pop pulse.
module edge_detect #(
   parameter int unsigned RD_EDGE = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic pulse
);

   logic prev_q;

   // Reset also loads the live level, so releasing reset never fakes an edge.
   always_ff @(posedge clk) begin
      prev_q <= d;
   end

   // Pulse is combinational in the cycle the new level is first seen.
   always_comb begin
      if (RD_EDGE != 0) begin
         pulse = ~reset & ~prev_q & d;
      end else begin
         pulse = ~reset & prev_q & ~d;
      end
   end

endmodule

// File: rtl/sparse_entry_buffer.sv
// Assembles big-endian multi-byte matrix entries from a UART byte stream and
// queues them in a show-ahead FIFO popped by an edge of the FPU done level.
module sparse_entry_buffer
   import sparse_pkg::*;
#(
   parameter int unsigned ENTRY_BYTES = DefaultEntryBytes,
   parameter int unsigned DEPTH       = DefaultDepth,
   parameter int unsigned RD_EDGE     = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rx_valid,
   input  logic [7:0]                   rx_byte,
   input  logic                         flush,
   input  logic                         fpu_complete,
   output logic [8*ENTRY_BYTES-1:0]     entry_data,
   output logic                         entry_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         overflow,
   output logic                         underflow,
   output logic                         busy
);

   localparam int unsigned EW   = 8 * ENTRY_BYTES;
   localparam int unsigned CntW = (ENTRY_BYTES > 1) ? $clog2(ENTRY_BYTES) : 1;
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned NumW = $clog2(DEPTH + 1);

   localparam logic [CntW-1:0] LastCnt = CntW'(ENTRY_BYTES - 1);

   asm_state_e          state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [EW-1:0]       asm_q, asm_d;

   logic                commit;
   logic                pop;
   logic                pop_ok;
   logic                push_ok;

   logic [EW-1:0]       mem_q [DEPTH];
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [NumW-1:0]     count_q, count_d;
   logic                overflow_q, underflow_q;

   edge_detect #(
      .RD_EDGE (RD_EDGE)
   ) u_edge_detect (
      .clk   (clk),
      .reset (reset),
      .d     (fpu_complete),
      .pulse (pop)
   );

   // Assembler state register; reset abandons any partial or committing entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Assembly register needs no reset: every byte is rewritten before commit.
   always_ff @(posedge clk) begin
      asm_q <= asm_d;
   end

   // Next-state: byte placement and counter; COMMIT accepts a new byte 0 like IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      if (flush) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle, StCommit: begin
               if (rx_valid) begin
                  asm_d[EW-1 -: 8] = rx_byte;
                  cnt_d   = (ENTRY_BYTES == 1) ? '0 : CntW'(1);
                  state_d = (ENTRY_BYTES == 1) ? StCommit : StAssemble;
               end else begin
                  state_d = StIdle;
               end
            end
            StAssemble: begin
               if (rx_valid) begin
                  for (int i = 0; i < ENTRY_BYTES; i++) begin
                     if (cnt_q == CntW'(i)) begin
                        asm_d[EW-1-8*i -: 8] = rx_byte;
                     end
                  end
                  if (cnt_q == LastCnt) begin
                     state_d = StCommit;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CntW'(1);
                  end
               end
            end
            default: begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs decoded from assembler state and FIFO occupancy.
   always_comb begin
      commit = (state_q == StCommit);
      busy   = (state_q != StIdle) || (count_q != '0);
   end

   // Write/pop qualification; a pop on a full FIFO makes room for a same-cycle commit.
   always_comb begin
      pop_ok  = pop & ~empty;
      push_ok = commit & (~full | pop_ok);
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + NumW'(1);
         2'b01:   count_d = count_q - NumW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, occupancy and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_d;
         if (commit && !push_ok) begin
            overflow_q <= 1'b1;
         end
         if (pop && empty) begin
            underflow_q <= 1'b1;
         end
      end
   end

   // Entry storage, written only when the commit is accepted.
   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         mem_q[wr_ptr_q] <= asm_q;
      end
   end

   // Status and show-ahead head entry.
   always_comb begin
      count       = count_q;
      full        = (count_q == NumW'(DEPTH));
      empty       = (count_q == '0);
      entry_valid = ~empty;
      overflow    = overflow_q;
      underflow   = underflow_q;
      entry_data  = mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_sparse_entry_buffer.sv
// Directed and randomized checks of sparse_entry_buffer against a queue-based model.
module tb_sparse_entry_buffer;

   localparam int unsigned EB    = 4;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        flush = 1'b0;
   logic        fpu_complete = 1'b0;
   logic [31:0] entry_data;
   logic        entry_valid;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
   logic        underflow;
   logic        busy;

   int checks = 0;
   int failures = 0;

   // Reference model: bytes gathered so far, one pending entry, FIFO contents, flags.
   logic [7:0]  m_bytes[$];
   logic [31:0] m_fifo[$];
   logic        m_pend = 1'b0;
   logic [31:0] m_pend_data = '0;
   logic        m_ovf = 1'b0;
   logic        m_udf = 1'b0;
   logic        m_prev = 1'b0;
   logic        fpu_lvl = 1'b0;

   sparse_entry_buffer #(
      .ENTRY_BYTES (EB),
      .DEPTH       (DEPTH),
      .RD_EDGE     (0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_valid     (rx_valid),
      .rx_byte      (rx_byte),
      .flush        (flush),
      .fpu_complete (fpu_complete),
      .entry_data   (entry_data),
      .entry_valid  (entry_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .overflow     (overflow),
      .underflow    (underflow),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic rv, input logic [7:0] rb, input logic fl,
                             input logic fpu, input logic rst);
      int  sz;
      logic pop;
      logic pop_ok;
      if (rst) begin
         m_bytes.delete();
         m_fifo.delete();
         m_pend = 1'b0;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
         m_prev = fpu;
      end else begin
         pop    = m_prev && !fpu;
         m_prev = fpu;
         sz     = m_fifo.size();
         pop_ok = pop && (sz > 0);
         if (pop && sz == 0) m_udf = 1'b1;
         if (pop_ok) void'(m_fifo.pop_front());
         if (m_pend) begin
            if (sz < DEPTH || pop_ok) m_fifo.push_back(m_pend_data);
            else m_ovf = 1'b1;
         end
         m_pend = 1'b0;
         if (fl) m_bytes.delete();
         else if (rv) m_bytes.push_back(rb);
         if (m_bytes.size() == EB) begin
            m_pend_data = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
            m_pend = 1'b1;
            m_bytes.delete();
         end
      end
   endtask

   task automatic check_all();
      chk("count", 32'(count), 32'(m_fifo.size()));
      chk("empty", 32'(empty), 32'(m_fifo.size() == 0));
      chk("full", 32'(full), 32'(m_fifo.size() == DEPTH));
      chk("entry_valid", 32'(entry_valid), 32'(m_fifo.size() != 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("busy", 32'(busy), 32'(m_bytes.size() != 0 || m_pend || m_fifo.size() != 0));
      if (m_fifo.size() != 0) chk("entry_data", entry_data, m_fifo[0]);
   endtask

   // One clock: drive inputs, advance model, sample on the falling edge.
   task automatic cycle(input logic rv, input logic [7:0] rb, input logic fl,
                        input logic fpu, input logic rst);
      rx_valid     = rv;
      rx_byte      = rb;
      flush        = fl;
      fpu_complete = fpu;
      reset        = rst;
      fpu_lvl      = fpu;
      model_step(rv, rb, fl, fpu, rst);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1'b1, b, 1'b0, fpu_lvl, 1'b0);
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[31:24]);
      send(w[23:16]);
      send(w[15:8]);
      send(w[7:0]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, fpu_lvl, 1'b0);
   endtask

   task automatic fpu(input logic lvl);
      cycle(1'b0, 8'h00, 1'b0, lvl, 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, fpu_lvl, 1'b1);
   endtask

   function automatic logic [31:0] word_k(input int k);
      logic [7:0] kb;
      kb = 8'(k);
      return {kb, 8'hC0, 8'hDE, kb ^ 8'h5A};
   endfunction

   initial begin
      @(negedge clk);
      do_reset(2);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(count), 32'd0);

      // Basic assembly, big-endian.
      send_word(32'h11223344);
      idle(1);
      chk("basic_data", entry_data, 32'h11223344);
      chk("basic_count", 32'(count), 32'd1);
      chk("basic_valid", 32'(entry_valid), 32'd1);
      fpu(1'b1);
      fpu(1'b0);
      chk("basic_popped", 32'(empty), 32'd1);

      // Five entries without pops: fifth is dropped.
      for (int k = 1; k <= 5; k++) send_word(word_k(k));
      idle(1);
      chk("ovf_full", 32'(full), 32'd1);
      chk("ovf_flag", 32'(overflow), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         chk("ovf_order", entry_data, word_k(k));
         fpu(1'b1);
         fpu(1'b0);
      end
      chk("ovf_drained", 32'(empty), 32'd1);

      // Flush discards a partial entry.
      do_reset(1);
      send(8'hAA);
      send(8'hBB);
      cycle(1'b0, 8'h00, 1'b1, fpu_lvl, 1'b0);
      send_word(32'h01020304);
      idle(2);
      chk("flush_data", entry_data, 32'h01020304);
      chk("flush_count", 32'(count), 32'd1);

      // Pop edges on an empty FIFO.
      do_reset(1);
      fpu(1'b1);
      chk("rise_no_udf", 32'(underflow), 32'd0);
      fpu(1'b0);
      chk("fall_udf", 32'(underflow), 32'd1);
      chk("fall_count", 32'(count), 32'd0);

      // Commit coinciding with a pop on a full FIFO.
      do_reset(1);
      fpu(1'b1);
      for (int k = 1; k <= 4; k++) send_word(word_k(k));
      idle(1);
      send(8'hDE);
      send(8'hAD);
      send(8'hBE);
      send(8'hEF);
      fpu(1'b0);
      chk("cp_count", 32'(count), 32'd4);
      chk("cp_ovf", 32'(overflow), 32'd0);
      for (int k = 2; k <= 4; k++) begin
         chk("cp_order", entry_data, word_k(k));
         fpu(1'b1);
         fpu(1'b0);
      end
      chk("cp_last", entry_data, 32'hDEADBEEF);

      // Reset mid-assembly abandons the entry.
      do_reset(1);
      send(8'h77);
      send(8'h88);
      do_reset(1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      send_word(32'hCAFEF00D);
      idle(1);
      chk("rst_mid_data", entry_data, 32'hCAFEF00D);
      chk("rst_mid_count", 32'(count), 32'd1);

      // Randomized traffic against the model.
      do_reset(1);
      for (int i = 0; i < 1500; i++) begin
         logic rv, fl, fp, rs;
         rv = ($urandom_range(0, 99) < 60);
         fl = ($urandom_range(0, 99) < 3);
         fp = ($urandom_range(0, 99) < 25) ? ~fpu_lvl : fpu_lvl;
         rs = ($urandom_range(0, 999) < 8);
         cycle(rv, 8'($urandom), fl, fp, rs);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
